// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 execute stage.
// Holds the opcode constants, the ALU operation enum, the writeback-select
// encodings, the bit positions of the E_control fields and a sign-extension
// helper.
package lc3_pkg;

    localparam int LC3_W = 16;

    // Opcodes, taken from IR[15:12]
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // ALU operation select
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_NOT = 2'b10,
        ALU_RSV = 2'b11
    } alu_ctrl_e;

    // Writeback select encodings carried through W_control
    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_PC  = 2'b01;
    localparam logic [1:0] WSEL_MEM = 2'b10;

    // Bit positions inside E_control = {alu_control, pcselect1, pcselect2, op2select}
    localparam int EC_ALU_HI  = 5;
    localparam int EC_ALU_LO  = 4;
    localparam int EC_PCS1_HI = 3;
    localparam int EC_PCS1_LO = 2;
    localparam int EC_PCS2    = 1;
    localparam int EC_OP2SEL  = 0;

    // Sign-extend the low w bits of v to the full datapath width.
    // Shifting the field to the top and arithmetically shifting back
    // discards the unused upper bits of v.
    function automatic logic [LC3_W-1:0] sext(input logic [LC3_W-1:0] v, input int w);
        logic signed [LC3_W-1:0] t;
        t = $signed(v << (LC3_W - w));
        return t >>> (LC3_W - w);
    endfunction

endpackage

// File: rtl/lc3_execute_if.sv
// lc3_execute_if: bundle of the execute stage's decode-side inputs,
// register-file and bypass inputs, and its registered outputs.
//   slave  : the execute stage (receives decode/bypass data, drives results)
//   master : the surrounding pipeline (drives decode/bypass data, reads results)
interface lc3_execute_if #(
    parameter int DW = 16
);
    logic          enable_execute;
    logic [5:0]    E_control;
    logic [1:0]    W_control_in;
    logic          Mem_control_in;
    logic [DW-1:0] IR;
    logic [DW-1:0] npc_in;
    logic [DW-1:0] VSR1;
    logic [DW-1:0] VSR2;
    logic          bypass_alu_1;
    logic          bypass_alu_2;
    logic          bypass_mem_1;
    logic          bypass_mem_2;
    logic [DW-1:0] Mem_Bypass_Val;
    logic [2:0]    sr1;
    logic [2:0]    sr2;
    logic [DW-1:0] aluout;
    logic [DW-1:0] pcout;
    logic [DW-1:0] M_Data;
    logic [1:0]    W_Control_out;
    logic          Mem_Control_out;
    logic [2:0]    NZP;
    logic [DW-1:0] IR_Exec;
    logic [2:0]    dr;

    modport slave (
        input  enable_execute, E_control, W_control_in, Mem_control_in, IR, npc_in,
               VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               Mem_Bypass_Val,
        output sr1, sr2, aluout, pcout, M_Data, W_Control_out, Mem_Control_out,
               NZP, IR_Exec, dr
    );

    modport master (
        output enable_execute, E_control, W_control_in, Mem_control_in, IR, npc_in,
               VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               Mem_Bypass_Val,
        input  sr1, sr2, aluout, pcout, M_Data, W_Control_out, Mem_Control_out,
               NZP, IR_Exec, dr
    );

endinterface

// File: rtl/lc3_alu.sv
// lc3_alu: combinational LC-3 ALU.
//   op1_i, op2_i   : operands
//   alu_ctrl_i     : ADD / AND / NOT / reserved
//   result_o       : result (ADD wraps modulo 2^16; reserved yields zero)
module lc3_alu
    import lc3_pkg::*;
(
    input  logic [LC3_W-1:0] op1_i,
    input  logic [LC3_W-1:0] op2_i,
    input  alu_ctrl_e        alu_ctrl_i,
    output logic [LC3_W-1:0] result_o
);

    // Operation select
    always_comb begin
        result_o = {LC3_W{1'b0}};
        case (alu_ctrl_i)
            ALU_ADD: result_o = op1_i + op2_i;
            ALU_AND: result_o = op1_i & op2_i;
            ALU_NOT: result_o = ~op1_i;
            ALU_RSV: result_o = {LC3_W{1'b0}};
            default: result_o = {LC3_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/lc3_execute.sv
// lc3_execute: execute stage of the LC-3 pipeline.
//   clock, reset : stage clock, asynchronous active-high reset
//   ex (slave)   : decode inputs (IR, npc_in, E/W/Mem control), register-file
//                  data (VSR1/2), bypass selects and Mem_Bypass_Val;
//                  combinational read addresses sr1/sr2; registered results
//                  aluout, pcout, M_Data, W_Control_out, Mem_Control_out,
//                  NZP, IR_Exec, dr.
// All registered outputs advance when enable_execute is high and hold
// otherwise, except NZP, which drops to 000 on any stalled edge so a branch
// condition is presented exactly once.
module lc3_execute
    import lc3_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic         clock,
    input  logic         reset,
    lc3_execute_if.slave ex
);

    logic [DW-1:0] op1_s, op2raw_s, op2_s, alu_res_s, offset_s, base_s, pc_res_s;
    logic [2:0]    nzp_s;
    logic [3:0]    opcode_s;
    alu_ctrl_e     alu_ctrl_s;

    logic [DW-1:0] aluout_q, aluout_d;
    logic [DW-1:0] pcout_q, pcout_d;
    logic [DW-1:0] mdata_q, mdata_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [1:0]    wctl_q, wctl_d;
    logic          mctl_q, mctl_d;
    logic [2:0]    nzp_q, nzp_d;
    logic [2:0]    dr_q, dr_d;

    assign opcode_s   = ex.IR[15:12];
    assign alu_ctrl_s = alu_ctrl_e'(ex.E_control[EC_ALU_HI:EC_ALU_LO]);

    // Operand 1 bypass: own ALU result wins over the memory-stage value
    always_comb begin
        if (ex.bypass_alu_1) begin
            op1_s = aluout_q;
        end else if (ex.bypass_mem_1) begin
            op1_s = ex.Mem_Bypass_Val;
        end else begin
            op1_s = ex.VSR1;
        end
    end

    // Operand 2 bypass (also the store data), same priority as operand 1
    always_comb begin
        if (ex.bypass_alu_2) begin
            op2raw_s = aluout_q;
        end else if (ex.bypass_mem_2) begin
            op2raw_s = ex.Mem_Bypass_Val;
        end else begin
            op2raw_s = ex.VSR2;
        end
    end

    // Operand 2 select: register/bypass value or imm5
    always_comb begin
        if (ex.E_control[EC_OP2SEL]) begin
            op2_s = op2raw_s;
        end else begin
            op2_s = sext(ex.IR, 5);
        end
    end

    lc3_alu u_alu (
        .op1_i      (op1_s),
        .op2_i      (op2_s),
        .alu_ctrl_i (alu_ctrl_s),
        .result_o   (alu_res_s)
    );

    // Address offset select by instruction format
    always_comb begin
        offset_s = {DW{1'b0}};
        case (ex.E_control[EC_PCS1_HI:EC_PCS1_LO])
            2'b00:   offset_s = sext(ex.IR, 11);
            2'b01:   offset_s = sext(ex.IR, 9);
            2'b10:   offset_s = sext(ex.IR, 6);
            2'b11:   offset_s = {DW{1'b0}};
            default: offset_s = {DW{1'b0}};
        endcase
    end

    // Address base: PC+1 for PC-relative forms, operand 1 for base+offset
    always_comb begin
        if (ex.E_control[EC_PCS2]) begin
            base_s = ex.npc_in;
        end else begin
            base_s = op1_s;
        end
    end

    assign pc_res_s = base_s + offset_s;

    // Branch-condition mask: BR carries its nzp bits, JMP is unconditional
    always_comb begin
        nzp_s = 3'b000;
        case (opcode_s)
            OP_BR:   nzp_s = ex.IR[11:9];
            OP_JMP:  nzp_s = 3'b111;
            default: nzp_s = 3'b000;
        endcase
    end

    // Register-file read addresses; stores read their source from IR[11:9]
    always_comb begin
        ex.sr1 = ex.IR[8:6];
        case (opcode_s)
            OP_ST, OP_STR, OP_STI: ex.sr2 = ex.IR[11:9];
            default:               ex.sr2 = ex.IR[2:0];
        endcase
    end

    // Next state: capture on enable, otherwise hold (NZP clears)
    always_comb begin
        if (ex.enable_execute) begin
            aluout_d = alu_res_s;
            pcout_d  = pc_res_s;
            mdata_d  = op2raw_s;
            ir_d     = ex.IR;
            wctl_d   = ex.W_control_in;
            mctl_d   = ex.Mem_control_in;
            nzp_d    = nzp_s;
            dr_d     = ex.IR[11:9];
        end else begin
            aluout_d = aluout_q;
            pcout_d  = pcout_q;
            mdata_d  = mdata_q;
            ir_d     = ir_q;
            wctl_d   = wctl_q;
            mctl_d   = mctl_q;
            nzp_d    = 3'b000;
            dr_d     = dr_q;
        end
    end

    // Stage output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluout_q <= {DW{1'b0}};
            pcout_q  <= {DW{1'b0}};
            mdata_q  <= {DW{1'b0}};
            ir_q     <= {DW{1'b0}};
            wctl_q   <= 2'b00;
            mctl_q   <= 1'b0;
            nzp_q    <= 3'b000;
            dr_q     <= 3'b000;
        end else begin
            aluout_q <= aluout_d;
            pcout_q  <= pcout_d;
            mdata_q  <= mdata_d;
            ir_q     <= ir_d;
            wctl_q   <= wctl_d;
            mctl_q   <= mctl_d;
            nzp_q    <= nzp_d;
            dr_q     <= dr_d;
        end
    end

    assign ex.aluout          = aluout_q;
    assign ex.pcout           = pcout_q;
    assign ex.M_Data          = mdata_q;
    assign ex.IR_Exec         = ir_q;
    assign ex.W_Control_out   = wctl_q;
    assign ex.Mem_Control_out = mctl_q;
    assign ex.NZP             = nzp_q;
    assign ex.dr              = dr_q;

endmodule

// File: tb/tb_lc3_execute.sv
// tb_lc3_execute: directed vectors with hand-computed results. Each issued
// cycle pushes its expected register state into a queue; a monitor pops and
// compares one entry after every clock edge at which an entry is pending.
module tb_lc3_execute;

    typedef struct {
        logic [15:0] aluout;
        logic [15:0] pcout;
        logic [15:0] mdata;
        logic [1:0]  wc;
        logic        mc;
        logic [2:0]  nzp;
        logic [15:0] ir;
        logic [2:0]  dr;
    } exp_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    exp_t last_exp;

    lc3_execute_if #(.DW(16)) ex_if ();

    lc3_execute #(.DW(16)) dut (
        .clock (clock),
        .reset (reset),
        .ex    (ex_if)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected
    // register state for the following rising edge. On a stall the previous
    // expectation carries over with NZP cleared.
    task automatic issue(input logic en, input logic [15:0] ir, input logic [15:0] npc,
                         input logic [15:0] vsr1, input logic [15:0] vsr2,
                         input logic [15:0] mbv, input logic [5:0] ec,
                         input logic [1:0] wc, input logic mc, input logic [3:0] byp,
                         input logic [2:0] sr1_e, input logic [2:0] sr2_e,
                         input logic [15:0] alu_e, input logic [15:0] pc_e,
                         input logic [15:0] md_e, input logic [2:0] nzp_e);
        exp_t e;
        @(negedge clock);
        ex_if.enable_execute = en;
        ex_if.IR             = ir;
        ex_if.npc_in         = npc;
        ex_if.VSR1           = vsr1;
        ex_if.VSR2           = vsr2;
        ex_if.Mem_Bypass_Val = mbv;
        ex_if.E_control      = ec;
        ex_if.W_control_in   = wc;
        ex_if.Mem_control_in = mc;
        {ex_if.bypass_alu_1, ex_if.bypass_alu_2, ex_if.bypass_mem_1, ex_if.bypass_mem_2} = byp;
        #1;
        chk("sr1", {13'd0, ex_if.sr1}, {13'd0, sr1_e});
        chk("sr2", {13'd0, ex_if.sr2}, {13'd0, sr2_e});
        if (en) begin
            e.aluout = alu_e;
            e.pcout  = pc_e;
            e.mdata  = md_e;
            e.wc     = wc;
            e.mc     = mc;
            e.nzp    = nzp_e;
            e.ir     = ir;
            e.dr     = ir[11:9];
        end else begin
            e     = last_exp;
            e.nzp = 3'b000;
        end
        last_exp = e;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " aluout"}, ex_if.aluout, 16'h0000);
        chk({tag, " pcout"}, ex_if.pcout, 16'h0000);
        chk({tag, " M_Data"}, ex_if.M_Data, 16'h0000);
        chk({tag, " IR_Exec"}, ex_if.IR_Exec, 16'h0000);
        chk({tag, " W_Control_out"}, {14'd0, ex_if.W_Control_out}, 16'h0000);
        chk({tag, " Mem_Control_out"}, {15'd0, ex_if.Mem_Control_out}, 16'h0000);
        chk({tag, " NZP"}, {13'd0, ex_if.NZP}, 16'h0000);
        chk({tag, " dr"}, {13'd0, ex_if.dr}, 16'h0000);
    endtask

    // Scoreboard monitor: compare after each edge with a pending expectation
    always @(posedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            #1;
            e = exp_q.pop_front();
            chk("aluout", ex_if.aluout, e.aluout);
            chk("pcout", ex_if.pcout, e.pcout);
            chk("M_Data", ex_if.M_Data, e.mdata);
            chk("W_Control_out", {14'd0, ex_if.W_Control_out}, {14'd0, e.wc});
            chk("Mem_Control_out", {15'd0, ex_if.Mem_Control_out}, {15'd0, e.mc});
            chk("NZP", {13'd0, ex_if.NZP}, {13'd0, e.nzp});
            chk("IR_Exec", ex_if.IR_Exec, e.ir);
            chk("dr", {13'd0, ex_if.dr}, {13'd0, e.dr});
        end
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clock    = 1'b0;
        reset    = 1'b1;
        n_checks = 0;
        n_fail   = 0;
        last_exp = '{16'h0, 16'h0, 16'h0, 2'b00, 1'b0, 3'b000, 16'h0, 3'b000};
        ex_if.enable_execute = 1'b0;
        ex_if.E_control      = 6'b000000;
        ex_if.W_control_in   = 2'b00;
        ex_if.Mem_control_in = 1'b0;
        ex_if.IR             = 16'h0000;
        ex_if.npc_in         = 16'h0000;
        ex_if.VSR1           = 16'h0000;
        ex_if.VSR2           = 16'h0000;
        ex_if.bypass_alu_1   = 1'b0;
        ex_if.bypass_alu_2   = 1'b0;
        ex_if.bypass_mem_1   = 1'b0;
        ex_if.bypass_mem_2   = 1'b0;
        ex_if.Mem_Bypass_Val = 16'h0000;

        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // en ir npc vsr1 vsr2 mbv ec wc mc byp{a1,a2,m1,m2} sr1 sr2 | alu pc mdata nzp
        // ADD R0,R1,R2
        issue(1'b1, 16'h1042, 16'h3000, 16'h0005, 16'h0007, 16'h0000, 6'b000001, 2'b00, 1'b0, 4'b0000,
              3'd1, 3'd2, 16'h000C, 16'h0047, 16'h0007, 3'b000);
        // ADD R1,R1,#-1 wraps to FFFF
        issue(1'b1, 16'h127F, 16'h3001, 16'h0000, 16'h0003, 16'h0000, 6'b000000, 2'b00, 1'b0, 4'b0000,
              3'd1, 3'd7, 16'hFFFF, 16'h027F, 16'h0003, 3'b000);
        // BRnp +5
        issue(1'b1, 16'h0A05, 16'h3001, 16'h1111, 16'h2222, 16'h0000, 6'b000110, 2'b00, 1'b0, 4'b0000,
              3'd0, 3'd5, 16'h1116, 16'h3006, 16'h2222, 3'b101);
        // stall: everything holds, NZP clears
        issue(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b111111, 2'b11, 1'b1, 4'b1111,
              3'd7, 3'd7, 16'h0, 16'h0, 16'h0, 3'b000);
        // ADD R0,R0,#9
        issue(1'b1, 16'h1029, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0, 4'b0000,
              3'd0, 3'd1, 16'h0009, 16'h0029, 16'h0000, 3'b000);
        // ADD R0,R0,#1 with both op1 bypasses: ALU forward (9) wins
        issue(1'b1, 16'h1021, 16'h0000, 16'h5555, 16'h0777, 16'd100, 6'b000000, 2'b00, 1'b0, 4'b1010,
              3'd0, 3'd1, 16'h000A, 16'h002A, 16'h0777, 3'b000);
        // memory forward only on op1
        issue(1'b1, 16'h1021, 16'h0000, 16'h5555, 16'h0000, 16'd100, 6'b000000, 2'b00, 1'b0, 4'b0010,
              3'd0, 3'd1, 16'h0065, 16'h0085, 16'h0000, 3'b000);
        // STR R2,R1,#3 with memory forward on store data
        issue(1'b1, 16'h7443, 16'h0000, 16'h4000, 16'h1234, 16'hBEEF, 6'b001000, 2'b00, 1'b0, 4'b0001,
              3'd1, 3'd2, 16'h4003, 16'h4003, 16'hBEEF, 3'b000);
        // AND R3,R1,R2, zero offset, W/Mem controls passed through
        issue(1'b1, 16'h5642, 16'h0000, 16'hF0F0, 16'h3C3C, 16'h0000, 6'b011101, 2'b01, 1'b1, 4'b0000,
              3'd1, 3'd2, 16'h3030, 16'hF0F0, 16'h3C3C, 3'b000);
        // NOT R4,R3 with ALU forward on both operands, base = npc
        issue(1'b1, 16'h98FF, 16'h4567, 16'h1111, 16'h0001, 16'h0000, 6'b101110, 2'b10, 1'b0, 4'b1100,
              3'd3, 3'd7, 16'hCFCF, 16'h4567, 16'h3030, 3'b000);
        // JMP R2, reserved ALU op gives 0
        issue(1'b1, 16'hC080, 16'h0000, 16'h3500, 16'hAAAA, 16'h0000, 6'b111101, 2'b00, 1'b0, 4'b0000,
              3'd2, 3'd0, 16'h0000, 16'h3500, 16'hAAAA, 3'b111);
        // ST R5,#-2 (negative 9-bit offset)
        issue(1'b1, 16'h3BFE, 16'h3000, 16'h0001, 16'h0002, 16'h0000, 6'b000111, 2'b00, 1'b0, 4'b0000,
              3'd7, 3'd5, 16'h0003, 16'h2FFE, 16'h0002, 3'b000);
        // ADD register wrap
        issue(1'b1, 16'h1042, 16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 6'b000001, 2'b00, 1'b0, 4'b0000,
              3'd1, 3'd2, 16'h0001, 16'h0041, 16'h0002, 3'b000);

        // Asynchronous reset mid-cycle while the stream is enabled
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("async reset");
        @(posedge clock);
        #1;
        chk_zero("reset held");
        @(negedge clock);
        reset = 1'b0;
        last_exp = '{16'h0, 16'h0, 16'h0, 2'b00, 1'b0, 3'b000, 16'h0, 3'b000};

        // Stream resumes cleanly after reset
        issue(1'b1, 16'h0A05, 16'h3001, 16'h1111, 16'h2222, 16'h0000, 6'b000110, 2'b00, 1'b0, 4'b0000,
              3'd0, 3'd5, 16'h1116, 16'h3006, 16'h2222, 3'b101);

        // Drain the scoreboard with a bounded wait
        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 8) begin
                @(posedge clock);
                guard++;
            end
            #2;
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_execute.md
# lc3_execute

Execute stage of the LC-3 pipeline; consumes the decode stage's outputs (`IR`, `npc_out`, `E_control`, `W_control`, `Mem_control`) plus register-file read data. It computes ALU results, effective/branch addresses and store data, applies operand bypassing, and registers results for the memory-access and writeback stages and the controller.

## Interface
Parameters:
- `DW`, 16, datapath/address width (fixed for LC-3; exposed for bench use only)

Ports:
- `clock`  in  1  stage clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `enable_execute`  in  1  stage advance enable from controller
- `E_control`  in  6  `{alu_control[1:0], pcselect1[1:0], pcselect2, op2select}` from decode
- `W_control_in`  in  2  writeback select from decode
- `Mem_control_in`  in  1  memory-indirect flag from decode
- `IR`  in  16  instruction from decode
- `npc_in`  in  16  PC+1 from decode
- `VSR1`, `VSR2`  in  16 each  register-file read data
- `bypass_alu_1`, `bypass_alu_2`  in  1 each  forward own `aluout` to operand 1/2
- `bypass_mem_1`, `bypass_mem_2`  in  1 each  forward `Mem_Bypass_Val` to operand 1/2
- `Mem_Bypass_Val`  in  16  memory-stage forward value
- `sr1`, `sr2`  out  3 each  combinational register-file read addresses
- `aluout`, `pcout`, `M_Data`  out  16 each  registered ALU result, address result, store data
- `W_Control_out`  out  2  registered `W_control_in`
- `Mem_Control_out`  out  1  registered `Mem_control_in`
- `NZP`  out  3  registered branch-condition mask
- `IR_Exec`  out  16  registered `IR`
- `dr`  out  3  registered destination register

## Operation
- Operands: `op1 = bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1`; `op2raw` likewise with `_2`/`VSR2`. ALU bypass has priority when both asserted.
- `op2 = op2select ? op2raw : sext(IR[4:0])`.
- ALU: `alu_control` 00 ADD `op1+op2`, 01 AND `op1&op2`, 10 NOT `~op1`, 11 reserved -> 0. Sums wrap modulo 2^16, no carry/overflow output.
- Offset by `pcselect1`: 00 `sext(IR[10:0])`, 01 `sext(IR[8:0])`, 10 `sext(IR[5:0])`, 11 zero. Base: `pcselect2 ? npc_in : op1`. `pcout = base + offset` modulo 2^16.
- `M_Data = op2raw` (store data, bypass applied).
- `sr1 = IR[8:6]`; `sr2 = IR[11:9]` for ST/STR/STI (opcodes 0011, 0111, 1011), else `IR[2:0]`. Combinational; not gated by enable.
- `dr = IR[11:9]`; `NZP = IR[11:9]` for BR (0000), `3'b111` for JMP (1100), else `3'b000`.

## Timing
- Reset (async assert, released synchronously by the environment): every registered output = 0.
- `enable_execute=1` at rising edge: all registered outputs update from current inputs; latency 1 cycle.
- `enable_execute=0`: all registered outputs hold, except `NZP` which clears to 000 at that edge (branch condition is one-shot; a stall never re-presents a branch).
- Back-to-back enabled cycles with `bypass_alu_*`: forwarded value is the `aluout` registered at the preceding edge.
- Reset mid-stall or mid-stream: outputs go to 0 immediately; no pending state survives.
- No internal handshake; flow control is entirely `enable_execute`.

## Structure
- Shared package `lc3_pkg`: opcode constants, `alu_control` enum, `W_control` encodings (00 ALU, 01 PC/LEA, 10 memory), E_control field-index constants, `sext` helper.
- One sub-module: `lc3_alu` (combinational, `op1`, `op2`, `alu_control` -> result). Bypass muxing, address adder and registers live in `lc3_execute`.

## Test plan
- ADD reg: `IR=16'h1042` (R0=R1+R2), `VSR1=5`, `VSR2=7`, `E_control=6'b000001` -> next edge `aluout=12`, `dr=0`, `NZP=000`.
- ADD imm wrap: `IR=16'h127F` (imm -1), `VSR1=0`, `op2select=0` -> `aluout=16'hFFFF`.
- BR: `IR=16'h0A05` (BRnp +5), `npc_in=16'h3001`, `pcselect1=01`, `pcselect2=1` -> `pcout=16'h3006`, `NZP=101`; next cycle with enable low -> `NZP=000`, `pcout` held.
- Bypass priority: `bypass_alu_1=bypass_mem_1=1`, prior `aluout=9`, `Mem_Bypass_Val=100`, ADD imm 1 -> `aluout=10`.
- Store: `IR=16'h7443` (STR R2,R1,#3), `VSR1=16'h4000`, `bypass_mem_2=1`, `Mem_Bypass_Val=16'hBEEF` -> `sr2=2`, `pcout=16'h4003`, `M_Data=16'hBEEF`.
- Async reset asserted mid-cycle during enabled stream -> all outputs 0 before the next clock edge.
